// File: rtl/mc_pkg.sv
// Shared encodings for mem_ctrl_arbiter: FSM states, access-size codes and the IO window base.
package mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } mc_state_e;

    localparam logic [1:0] SIZE_1B  = 2'd0;
    localparam logic [1:0] SIZE_2B  = 2'd1;
    localparam logic [1:0] SIZE_ILL = 2'd2;
    localparam logic [1:0] SIZE_4B  = 2'd3;

    localparam logic [31:0] MC_IO_ADDR = 32'h0003_0000;

    // The reserved size code falls back to a full word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SIZE_1B:  n = 3'd1;
            SIZE_2B:  n = 3'd2;
            SIZE_ILL: n = 3'd4;
            SIZE_4B:  n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Byte-serial RAM/IO port owner: MEM > IF priority, N-byte read done N+1 cycles after grant, write N.
// rdy_in low freezes everything; MC_IO_FULL_EN stalls IO-window stores while io_buffer_full is high.
module mem_ctrl_arbiter
    import mc_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(MC_IO_ADDR)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              branch_or_not,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_instru,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic              io_buffer_full,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    mc_state_e         state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       lane_buf;
    logic [1:0]        lane_sel;
    logic              if_done_d, mem_done_d;
    logic [31:0]       if_instru_d, mem_rdata_d;
    logic              io_stall;

    assign cur_addr = addr_q + ADDR_W'(cnt_q);

`ifdef MC_IO_FULL_EN
    assign io_stall = (state_q == ST_MEM_WR) && io_buffer_full &&
                      ((cur_addr == IO_ADDR) || (cur_addr == IO_ADDR + ADDR_W'(4)));
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_stall       = 1'b0;
`endif

    // RAM data lags its address by one cycle, so counter value k lands byte k-1.
    always_comb begin
        lane_sel = cnt_q[1:0] - 2'd1;
        lane_buf = buf_q;
        case (lane_sel)
            2'd0: lane_buf[7:0]   = ram_din;
            2'd1: lane_buf[15:8]  = ram_din;
            2'd2: lane_buf[23:16] = ram_din;
            2'd3: lane_buf[31:24] = ram_din;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_instru_d = if_instru;
        mem_rdata_d = mem_rdata;
        case (state_q)
            ST_IDLE: begin
                if (!if_done && !mem_done) begin
                    if (mem_req) begin
                        state_d  = mem_we ? ST_MEM_WR : ST_MEM_RD;
                        addr_d   = mem_addr;
                        wdata_d  = mem_wdata;
                        nbytes_d = size_bytes(mem_size);
                        cnt_d    = 3'd0;
                        buf_d    = '0;
                    end else if (if_req && !branch_or_not) begin
                        state_d  = ST_IF_RD;
                        addr_d   = if_addr;
                        nbytes_d = 3'd4;
                        cnt_d    = 3'd0;
                        buf_d    = '0;
                    end
                end
            end
            ST_IF_RD, ST_MEM_RD: begin
                if (state_q == ST_IF_RD && branch_or_not) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q != 3'd0)
                        buf_d = lane_buf;
                    if (cnt_q == nbytes_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                        if (state_q == ST_IF_RD) begin
                            if_done_d   = 1'b1;
                            if_instru_d = lane_buf;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = lane_buf;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_MEM_WR: begin
                if (!io_stall) begin
                    if (cnt_q == nbytes_q - 3'd1) begin
                        state_d    = ST_IDLE;
                        cnt_d      = 3'd0;
                        mem_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_a    = '0;
        ram_dout = '0;
        ram_wr   = 1'b0;
        case (state_q)
            ST_IF_RD, ST_MEM_RD: begin
                if (cnt_q < nbytes_q)
                    ram_a = cur_addr;
            end
            ST_MEM_WR: begin
                ram_a    = cur_addr;
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                ram_wr   = rdy_in && !io_stall;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            nbytes_q  <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_instru <= '0;
            mem_rdata <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nbytes_q  <= nbytes_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            buf_q     <= buf_d;
            if_done   <= if_done_d;
            mem_done  <= mem_done_d;
            if_instru <= if_instru_d;
            mem_rdata <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed bench for mem_ctrl_arbiter with a one-cycle-latency byte RAM model gated by rdy_in.
module tb_mem_ctrl_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        branch_or_not;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_instru;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        io_buffer_full;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    logic [7:0]  ram [0:4095];
    logic        ram_init;
    int          checks;
    int          failures;

    mem_ctrl_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .branch_or_not  (branch_or_not),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_instru      (if_instru),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_size       (mem_size),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .io_buffer_full (io_buffer_full),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_a          (ram_a),
        .ram_wr         (ram_wr)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h13;
            ram[12'h200] <= 8'hEF; ram[12'h201] <= 8'hBE;
            ram[12'h202] <= 8'hAD; ram[12'h203] <= 8'hDE;
            ram[12'h140] <= 8'h78; ram[12'h141] <= 8'h56;
            ram[12'h142] <= 8'h34; ram[12'h143] <= 8'h12;
            ram[12'hFFF] <= 8'h5A; ram[12'h000] <= 8'hA5;
            ram_din <= 8'h00;
        end else if (rdy_in) begin
            if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
            ram_din <= ram[ram_a[11:0]];
        end
    end

    task automatic run_mem(input logic we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output int at);
        mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
        at = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            if (mem_done === 1'b1) begin at = c; break; end
        end
        mem_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        ram_init = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++; if ({if_done, mem_done} !== 2'b00) begin failures++; $display("FAIL reset_done: got %b expected 00", {if_done, mem_done}); end
        checks++; if (ram_wr !== 1'b0) begin failures++; $display("FAIL reset_ram_wr: got %b expected 0", ram_wr); end
        checks++; if (ram_a !== 32'h0) begin failures++; $display("FAIL reset_ram_a: got %h expected 0", ram_a); end
        checks++; if (ram_dout !== 8'h0) begin failures++; $display("FAIL reset_ram_dout: got %h expected 0", ram_dout); end
        checks++; if ({if_instru, mem_rdata} !== 64'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", {if_instru, mem_rdata}); end
        ram_init = 1'b0;
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++; if (ram_a !== 32'h0) begin failures++; $display("FAIL reset_idle_after_release: got %h expected 0", ram_a); end
    endtask

    task automatic test_if_fetch();
        int done_at = -1;
        if_addr = 32'h100; if_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_in);
            if (c <= 4) begin
                checks++;
                if (ram_a !== 32'h100 + 32'(c - 1) || ram_wr !== 1'b0) begin
                    failures++; $display("FAIL if_fetch_addr c=%0d: got a=%h wr=%b expected a=%h wr=0", c, ram_a, ram_wr, 32'h100 + 32'(c - 1));
                end
            end
            if (if_done === 1'b1) begin done_at = c; break; end
        end
        if_req = 1'b0;
        checks++; if (done_at != 6) begin failures++; $display("FAIL if_fetch_latency: got %0d expected 6", done_at); end
        checks++; if (if_instru !== 32'h0000_0013) begin failures++; $display("FAIL if_fetch_data: got %h expected 00000013", if_instru); end
        @(negedge clk_in);
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL if_done_pulse: got %b expected 0", if_done); end
    endtask

    task automatic test_arbitration();
        int m_at = -1;
        int i_at = -1;
        mem_we = 1'b0; mem_size = 2'd3; mem_addr = 32'h200; mem_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            if (mem_done === 1'b1 && m_at < 0) begin m_at = c; mem_req = 1'b0; end
            if (if_done === 1'b1) begin i_at = c; break; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        checks++; if (m_at != 6) begin failures++; $display("FAIL arb_mem_first: got %0d expected 6", m_at); end
        checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL arb_mem_rdata: got %h expected deadbeef", mem_rdata); end
        checks++; if (i_at != 13) begin failures++; $display("FAIL arb_if_after: got %0d expected 13", i_at); end
        checks++; if (if_instru !== 32'h0000_0013) begin failures++; $display("FAIL arb_if_data: got %h expected 00000013", if_instru); end
    endtask

    task automatic test_store();
        mem_we = 1'b1; mem_size = 2'd1; mem_addr = 32'h300; mem_wdata = 32'h0000_1234; mem_req = 1'b1;
        @(negedge clk_in);
        checks++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h300, 8'h34}) begin failures++; $display("FAIL store_byte0: got wr=%b a=%h d=%h expected 1 300 34", ram_wr, ram_a, ram_dout); end
        @(negedge clk_in);
        checks++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h301, 8'h12}) begin failures++; $display("FAIL store_byte1: got wr=%b a=%h d=%h expected 1 301 12", ram_wr, ram_a, ram_dout); end
        @(negedge clk_in);
        checks++; if ({mem_done, ram_wr} !== 2'b10) begin failures++; $display("FAIL store_done: got done=%b wr=%b expected 1 0", mem_done, ram_wr); end
        mem_req = 1'b0;
        checks++; if ({ram[12'h301], ram[12'h300]} !== 16'h1234) begin failures++; $display("FAIL store_ram: got %h expected 1234", {ram[12'h301], ram[12'h300]}); end
        @(negedge clk_in);
    endtask

    task automatic test_loads();
        int at = -1;
        mem_we = 1'b0; mem_size = 2'd1; mem_addr = 32'hFFFF_FFFF; mem_req = 1'b1;
        @(negedge clk_in);
        checks++; if (ram_a !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_addr0: got %h expected ffffffff", ram_a); end
        @(negedge clk_in);
        checks++; if (ram_a !== 32'h0) begin failures++; $display("FAIL wrap_addr1: got %h expected 00000000", ram_a); end
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk_in);
            if (mem_done === 1'b1) begin at = c; break; end
        end
        mem_req = 1'b0;
        checks++; if (at != 4) begin failures++; $display("FAIL load2_latency: got %0d expected 4", at); end
        checks++; if (mem_rdata !== 32'h0000_A55A) begin failures++; $display("FAIL load2_data: got %h expected 0000a55a", mem_rdata); end
        @(negedge clk_in);
        run_mem(1'b0, 2'd0, 32'h201, 32'h0, at);
        checks++; if (at != 3) begin failures++; $display("FAIL load1_latency: got %0d expected 3", at); end
        checks++; if (mem_rdata !== 32'h0000_00BE) begin failures++; $display("FAIL load1_zext: got %h expected 000000be", mem_rdata); end
        @(negedge clk_in);
        run_mem(1'b0, 2'd2, 32'h200, 32'h0, at);
        checks++; if (at != 6 || mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_size2_as_word: got at=%0d d=%h expected 6 deadbeef", at, mem_rdata); end
        @(negedge clk_in);
    endtask

    task automatic test_branch();
        int at = -1;
        bit wr_seen = 1'b0;
        if_addr = 32'h100; if_req = 1'b1; branch_or_not = 1'b1;
        @(negedge clk_in);
        checks++; if (ram_a !== 32'h0) begin failures++; $display("FAIL branch_blocks_grant: got %h expected 0", ram_a); end
        branch_or_not = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++; if (ram_a !== 32'h101) begin failures++; $display("FAIL branch_pre_abort: got %h expected 101", ram_a); end
        branch_or_not = 1'b1;
        @(negedge clk_in);
        checks++; if ({if_done, ram_a} !== 33'h0) begin failures++; $display("FAIL branch_abort_idle: got done=%b a=%h expected 0 0", if_done, ram_a); end
        branch_or_not = 1'b0; if_addr = 32'h200;
        for (int c = 4; c <= 15; c++) begin
            @(negedge clk_in);
            if (ram_wr !== 1'b0) wr_seen = 1'b1;
            if (if_done === 1'b1) begin at = c; break; end
        end
        if_req = 1'b0;
        checks++; if (at != 9) begin failures++; $display("FAIL branch_refetch_latency: got %0d expected 9", at); end
        checks++; if (if_instru !== 32'hDEAD_BEEF) begin failures++; $display("FAIL branch_refetch_data: got %h expected deadbeef", if_instru); end
        checks++; if (wr_seen) begin failures++; $display("FAIL branch_no_write: got ram_wr=1 expected 0"); end
        @(negedge clk_in);
    endtask

    task automatic test_rdy_freeze();
        int at = -1;
        if_addr = 32'h140; if_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            if (c == 2) rdy_in = 1'b0;
            if (c >= 3 && c <= 5) begin
                checks++;
                if ({if_done, ram_a} !== {1'b0, 32'h141}) begin failures++; $display("FAIL freeze_hold c=%0d: got done=%b a=%h expected 0 141", c, if_done, ram_a); end
            end
            if (c == 5) rdy_in = 1'b1;
            if (if_done === 1'b1) begin at = c; break; end
        end
        if_req = 1'b0;
        checks++; if (at != 9) begin failures++; $display("FAIL freeze_latency: got %0d expected 9", at); end
        checks++; if (if_instru !== 32'h1234_5678) begin failures++; $display("FAIL freeze_data: got %h expected 12345678", if_instru); end
        @(negedge clk_in);
    endtask

    task automatic test_rdy_write();
        int at = -1;
        mem_we = 1'b1; mem_size = 2'd3; mem_addr = 32'h310; mem_wdata = 32'h4433_2211; mem_req = 1'b1;
        @(negedge clk_in);
        checks++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h310, 8'h11}) begin failures++; $display("FAIL wr4_byte0: got wr=%b a=%h d=%h expected 1 310 11", ram_wr, ram_a, ram_dout); end
        @(negedge clk_in);
        rdy_in = 1'b0;
        #1;
        checks++; if ({ram_wr, ram_a} !== {1'b0, 32'h311}) begin failures++; $display("FAIL rdy_low_forces_wr: got wr=%b a=%h expected 0 311", ram_wr, ram_a); end
        @(negedge clk_in);
        checks++; if ({ram_wr, ram_a} !== {1'b0, 32'h311}) begin failures++; $display("FAIL rdy_low_hold: got wr=%b a=%h expected 0 311", ram_wr, ram_a); end
        rdy_in = 1'b1;
        #1;
        checks++; if ({ram_wr, ram_dout} !== {1'b1, 8'h22}) begin failures++; $display("FAIL rdy_resume: got wr=%b d=%h expected 1 22", ram_wr, ram_dout); end
        for (int c = 4; c <= 12; c++) begin
            @(negedge clk_in);
            if (mem_done === 1'b1) begin at = c; break; end
        end
        mem_req = 1'b0;
        checks++; if (at != 6) begin failures++; $display("FAIL wr4_latency: got %0d expected 6", at); end
        checks++; if ({ram[12'h313], ram[12'h312], ram[12'h311], ram[12'h310]} !== 32'h4433_2211) begin
            failures++; $display("FAIL wr4_ram: got %h expected 44332211", {ram[12'h313], ram[12'h312], ram[12'h311], ram[12'h310]});
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid();
        int at = -1;
        mem_we = 1'b1; mem_size = 2'd3; mem_addr = 32'h320; mem_wdata = 32'hA1A2_A3A4; mem_req = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        checks++; if ({ram_wr, ram_a, ram_dout} !== 41'h0) begin failures++; $display("FAIL rst_mid_ram: got wr=%b a=%h d=%h expected 0 0 0", ram_wr, ram_a, ram_dout); end
        checks++; if ({mem_rdata, if_instru} !== 64'h0) begin failures++; $display("FAIL rst_mid_data: got %h expected 0", {mem_rdata, if_instru}); end
        mem_req = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++; if ({mem_done, ram_wr, ram_a} !== 34'h0) begin failures++; $display("FAIL rst_mid_idle: got done=%b wr=%b a=%h expected 0 0 0", mem_done, ram_wr, ram_a); end
        run_mem(1'b0, 2'd0, 32'h312, 32'h0, at);
        checks++; if (at != 3 || mem_rdata !== 32'h0000_0033) begin failures++; $display("FAIL rst_mid_recover: got at=%0d d=%h expected 3 00000033", at, mem_rdata); end
        @(negedge clk_in);
    endtask

    task automatic test_io();
        mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h0003_0000; mem_wdata = 32'h0000_0077;
        io_buffer_full = 1'b1; mem_req = 1'b1;
`ifdef MC_IO_FULL_EN
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk_in);
            checks++; if ({ram_wr, ram_a} !== {1'b0, 32'h0003_0000}) begin failures++; $display("FAIL io_stall c=%0d: got wr=%b a=%h expected 0 30000", c, ram_wr, ram_a); end
        end
        @(negedge clk_in);
        io_buffer_full = 1'b0;
        #1;
        checks++; if ({ram_wr, ram_dout} !== {1'b1, 8'h77}) begin failures++; $display("FAIL io_release: got wr=%b d=%h expected 1 77", ram_wr, ram_dout); end
        @(negedge clk_in);
        checks++; if (mem_done !== 1'b1) begin failures++; $display("FAIL io_done: got %b expected 1", mem_done); end
`else
        @(negedge clk_in);
        checks++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h0003_0000, 8'h77}) begin failures++; $display("FAIL io_no_stall: got wr=%b a=%h d=%h expected 1 30000 77", ram_wr, ram_a, ram_dout); end
        @(negedge clk_in);
        checks++; if (mem_done !== 1'b1) begin failures++; $display("FAIL io_done: got %b expected 1", mem_done); end
`endif
        mem_req = 1'b0; io_buffer_full = 1'b0;
        checks++; if (ram[12'h000] !== 8'h77) begin failures++; $display("FAIL io_ram: got %h expected 77", ram[12'h000]); end
        @(negedge clk_in);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_in = 1'b0; rdy_in = 1'b1; branch_or_not = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        io_buffer_full = 1'b0; ram_init = 1'b1;
        test_reset();
        test_if_fetch();
        test_arbitration();
        @(negedge clk_in);
        test_store();
        test_loads();
        test_branch();
        test_rdy_freeze();
        test_rdy_write();
        test_reset_mid();
        test_io();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
